// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bus bundle for the L1 data cache controller.
// Signal names keep the cache's point of view (_i = into the cache).
interface dcache_controller_if;
    // CPU MEM-stage side
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    // Line-based data memory side
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    // Cache controller view
    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_data_i, mem_ack_i,
        output cpu_rdata_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    // CPU / memory view
    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_data_i, mem_ack_i,
        input  cpu_rdata_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete combinationally; misses stall the CPU while an optional
// dirty-victim write-back and a line refill run over the memory handshake.
module dcache_controller #(
    parameter  int INDEX_W = 5,
    localparam int TAG_W   = 32 - 5 - INDEX_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dcache_controller_if.slave   bus,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [255:0]       data_q [LINES];
    logic [31:0]        hit_cnt_q;
    logic [31:0]        miss_cnt_q;
    // Set while the outstanding access has already missed once, so its
    // eventual completion is not counted as a hit.
    logic               missed_q;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] idx;
    logic [7:0]         word_lsb;
    logic               hit;
    logic               complete;
    logic               miss_start;
    logic               unused_addr_bits;

    assign req_tag          = bus.cpu_addr_i[31:5+INDEX_W];
    assign idx              = bus.cpu_addr_i[4+INDEX_W:5];
    assign word_lsb         = {bus.cpu_addr_i[4:2], 5'b0};
    assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

    assign hit             = bus.cpu_req_i & valid_q[idx] & (tag_q[idx] == req_tag);
    assign bus.cpu_stall_o = bus.cpu_req_i & ((state_q != IDLE) | ~hit);
    assign complete        = bus.cpu_req_i & ~bus.cpu_stall_o;
    assign bus.cpu_rdata_o = hit ? data_q[idx][word_lsb +: 32] : 32'd0;

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

    // Next-state and memory-bus decode; memory outputs depend only on the
    // registered state (plus the held request address) so they stay stable
    // across a whole phase and drop to idle as soon as the state does.
    always_comb begin
        state_d          = state_q;
        miss_start       = 1'b0;
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = 32'd0;
        bus.mem_data_o   = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req_i && !hit) begin
                    miss_start = 1'b1;
                    state_d    = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {tag_q[idx], idx, 5'b0};
                bus.mem_data_o   = data_q[idx];
                if (bus.mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = {req_tag, idx, 5'b0};
                if (bus.mem_ack_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: FSM, line valid/dirty flags and statistics counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
            missed_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
                missed_q   <= 1'b1;
            end else if (complete) begin
                missed_q <= 1'b0;
            end
            if (complete && !missed_q) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (state_q == REFILL) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (complete && bus.cpu_we_i) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: refill a whole line or merge one stored word.
    always_ff @(posedge clk_i) begin
        if (state_q == REFILL) begin
            data_q[idx] <= bus.mem_data_i;
            tag_q[idx]  <= req_tag;
        end else if (complete && bus.cpu_we_i) begin
            data_q[idx][word_lsb +: 32] <= bus.cpu_wdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 10-cycle line memory model.
module tb_dcache_controller;

    logic        clk;
    logic        rst_n;
    logic        init_mem;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    dcache_controller_if bus ();

    dcache_controller #(.INDEX_W(5)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .bus        (bus),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: idle -> busy on enable, ack when the counter reaches 9,
    // data registered on the ack edge.
    logic [255:0] mem [64];
    logic         mbusy;
    int           mcnt;
    logic [255:0] mem_rd;
    int           n_reads, n_writes, wr_cyc;
    logic [31:0]  last_rd_addr, last_wr_addr;
    logic [255:0] last_wr_data;

    assign bus.mem_ack_i  = mbusy && (mcnt == 9);
    assign bus.mem_data_i = mem_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
        end else if (!mbusy) begin
            if (bus.mem_enable_o) begin
                mbusy <= 1'b1;
                mcnt  <= 0;
            end
        end else if (mcnt == 9) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++)
                for (int w = 0; w < 8; w++)
                    mem[i][32*w +: 32] <= 32'hA000_0000 | (i << 8) | w;
            n_reads  <= 0;
            n_writes <= 0;
            mem_rd   <= '0;
        end else if (bus.mem_ack_i) begin
            if (bus.mem_write_o) begin
                mem[bus.mem_addr_o[10:5]] <= bus.mem_data_o;
                n_writes     <= n_writes + 1;
                last_wr_addr <= bus.mem_addr_o;
                last_wr_data <= bus.mem_data_o;
            end else begin
                mem_rd       <= mem[bus.mem_addr_o[10:5]];
                n_reads      <= n_reads + 1;
                last_rd_addr <= bus.mem_addr_o;
            end
        end
    end

    always @(posedge clk) begin
        if (init_mem) wr_cyc <= 0;
        else if (bus.mem_write_o) wr_cyc <= wr_cyc + 1;
    end

    int n_vec, n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one access, count stalled cycles, capture rdata in the
    // completing cycle, then drop the request right after that edge.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int stalls, output logic [31:0] rd);
        @(negedge clk);
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wd;
        stalls = 0;
        #1;
        while (bus.cpu_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rd = bus.cpu_rdata_o;
        @(posedge clk);
        #1;
        bus.cpu_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int          st, reads0, writes0, wrc0;
    logic [31:0] rd;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        init_mem = 1'b1;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = 32'd0;
        bus.cpu_wdata_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_enable_o}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_write_o}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        init_mem = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Cold load: ALLOCATE only, 13 stalled cycles
        @(negedge clk);
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_0040;
        #1;
        chk("cold_rdata_while_miss", bus.cpu_rdata_o, 32'd0);
        bus.cpu_req_i = 1'b0;
        access(1'b0, 32'h0000_0040, 32'd0, st, rd);
        chk("cold_stall", st, 32'd13);
        chk("cold_rdata", rd, 32'hA000_0200);
        chk("cold_reads", n_reads, 32'd1);
        chk("cold_writes", n_writes, 32'd0);
        chk("cold_rd_addr", last_rd_addr, 32'h0000_0040);
        chk("cold_miss_cnt", miss_cnt, 32'd1);
        chk("cold_hit_cnt", hit_cnt, 32'd0);

        // Store hit then load hit
        access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, st, rd);
        chk("st_stall", st, 32'd0);
        access(1'b0, 32'h0000_0044, 32'd0, st, rd);
        chk("ld_stall", st, 32'd0);
        chk("ld_rdata", rd, 32'hDEAD_BEEF);
        chk("ld_hit_cnt", hit_cnt, 32'd2);
        chk("ld_reads", n_reads, 32'd1);
        chk("ld_writes", n_writes, 32'd0);

        // Conflict miss with dirty victim: write-back then fetch
        access(1'b0, 32'h0000_0440, 32'd0, st, rd);
        chk("wb_stall", st, 32'd24);
        chk("wb_writes", n_writes, 32'd1);
        chk("wb_addr", last_wr_addr, 32'h0000_0040);
        chk("wb_word1", last_wr_data[63:32], 32'hDEAD_BEEF);
        chk("wb_word0", last_wr_data[31:0], 32'hA000_0200);
        chk("wb_rd_addr", last_rd_addr, 32'h0000_0440);
        chk("wb_rdata", rd, 32'hA000_2200);
        chk("wb_miss_cnt", miss_cnt, 32'd2);
        chk("wb_hit_cnt", hit_cnt, 32'd2);

        // Conflict miss with clean victim: no write phase at all
        wrc0 = wr_cyc;
        access(1'b0, 32'h0000_0044, 32'd0, st, rd);
        chk("clean_stall", st, 32'd13);
        chk("clean_write_cycles", wr_cyc - wrc0, 32'd0);
        chk("clean_writes", n_writes, 32'd1);
        chk("clean_rdata", rd, 32'hDEAD_BEEF);
        chk("clean_miss_cnt", miss_cnt, 32'd3);

        // Reset asserted in the middle of an ALLOCATE wait
        @(negedge clk);
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_0080;
        repeat (4) @(negedge clk);
        #1;
        chk("alloc_en", {31'd0, bus.mem_enable_o}, 32'd1);
        chk("alloc_we", {31'd0, bus.mem_write_o}, 32'd0);
        chk("alloc_addr", bus.mem_addr_o, 32'h0000_0080);
        #1;
        rst_n = 1'b0;
        bus.cpu_req_i = 1'b0;
        #1;
        chk("midrst_en", {31'd0, bus.mem_enable_o}, 32'd0);
        chk("midrst_addr", bus.mem_addr_o, 32'd0);
        chk("midrst_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
        chk("midrst_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reads0 = n_reads;
        access(1'b0, 32'h0000_0044, 32'd0, st, rd);
        chk("reload_stall", st, 32'd13);
        chk("reload_reads", n_reads - reads0, 32'd1);
        chk("reload_rdata", rd, 32'hDEAD_BEEF);
        chk("reload_miss_cnt", miss_cnt, 32'd1);
        chk("reload_hit_cnt", hit_cnt, 32'd0);

        // Hit counter wrap
        @(negedge clk);
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt_q;
        #1;
        chk("wrap_preload", hit_cnt, 32'hFFFF_FFFF);
        access(1'b0, 32'h0000_0040, 32'd0, st, rd);
        chk("wrap_stall", st, 32'd0);
        chk("wrap_rdata", rd, 32'hA000_0200);
        chk("wrap_hit_cnt", hit_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller between the CPU MEM stage and the 256-bit line-based data memory.
- Serves 32-bit word loads and stores on hits with zero added latency.
- On a miss it stalls the CPU, writes back a dirty victim line if needed, refills the line through the memory enable/write/ack handshake, then completes the access as a hit.

Parameters:
- INDEX_W, 5, index bits. Number of lines = 2^INDEX_W (default 32 lines × 32 B = 1 KB).
- TAG_W, 32-5-INDEX_W, tag bits. Derived; not to be overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- cpu_req_i  in  1  access request.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address. Bits [4:2] select the word; bits [1:0] are ignored.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data. Valid in the completing cycle.
- cpu_stall_o  out  1  CPU must hold all cpu_* inputs stable while this is high.
- mem_enable_o  out  1  memory transaction request.
- mem_write_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line-aligned byte address; bits [4:0] = 0.
- mem_data_o  out  256  write-back line data.
- mem_data_i  in  256  fetched line. Valid in the cycle after mem_ack_i.
- mem_ack_i  in  1  one-cycle transaction-done pulse.
- hit_cnt_o  out  32  number of completed accesses that hit on first presentation.
- miss_cnt_o  out  32  number of misses.

Behaviour:
- Address split: tag = addr[31:5+INDEX_W], index = addr[4+INDEX_W:5], word = addr[4:2].
- Per-line storage: valid bit, dirty bit, tag, and 256-bit data. Word w occupies data bits [32w+31:32w].
- hit = cpu_req_i & valid[index] & (tag[index] == req tag).
- cpu_stall_o = cpu_req_i & ((state != IDLE) | ~hit). This is combinational.
- An access completes at the rising edge where cpu_req_i = 1 and cpu_stall_o = 0.
  - Load: cpu_rdata_o = selected word, combinational in that cycle.
  - Store: selected word is replaced at that edge and dirty[index] is set.
- cpu_rdata_o is 0 whenever no hit is present.
- States and transitions:
  - IDLE:
    - req & ~hit & victim valid & dirty -> WRITEBACK.
    - req & ~hit & otherwise -> ALLOCATE.
    - miss_cnt_o increments on this transition.
  - WRITEBACK:
    - mem_enable_o = 1, mem_write_o = 1.
    - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
    - mem_ack_i -> ALLOCATE.
  - ALLOCATE:
    - mem_enable_o = 1, mem_write_o = 0.
    - mem_addr_o = {req tag, index, 5'b0}.
    - mem_ack_i -> REFILL.
  - REFILL:
    - mem_enable_o = 0.
    - Line data <= mem_data_i; tag <= req tag; valid <= 1; dirty <= 0.
    - -> IDLE unconditionally. The held request then hits in IDLE.
- mem_enable_o, mem_write_o and mem_addr_o are registered-state decodes. They stay stable for the whole WRITEBACK or ALLOCATE phase.
- mem_enable_o is 0 in IDLE and REFILL. This guarantees the memory returns to idle between transactions.
- hit_cnt_o increments on completion only if that access never caused a miss. An access that completes after a refill is not counted as a hit.
- Both counters wrap from 0xFFFFFFFF to 0.
- Reset (asynchronous, any state including mid-transaction):
  - state = IDLE; all valid and dirty bits = 0; counters = 0.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0.
  - Data and tag arrays are not reset.
  - Dirty data and any in-flight memory transaction are abandoned.
- cpu_req_i deasserted in IDLE: no state change; stall low.
- Inputs changing while stalled is a protocol violation; behaviour is undefined.
- mem_ack_i outside WRITEBACK and ALLOCATE is ignored.
- The block must not rely on a fixed memory latency. Only mem_ack_i ends a phase.

Test Plan:
- Cold load 0x00000040 after reset, 10-cycle data memory model (idle→wait on enable, ack at count 9, data registered on the ack edge):
  - stall high 13 cycles; one mem read at 0x00000040, no write;
  - rdata = word 0 of memory line 2; miss_cnt_o = 1, hit_cnt_o = 0.
- Store 0xDEADBEEF to 0x00000044, then load 0x00000044:
  - both complete with zero stall;
  - load returns 0xDEADBEEF; hit_cnt_o = 2; no memory traffic.
- Load 0x00000440 (same index 2, new tag) with line 2 dirty:
  - stall 24 cycles;
  - write-back at 0x00000040 carries 0xDEADBEEF in word 1;
  - then fetch at 0x00000440; miss_cnt_o = 2.
- Load conflicting address with victim clean:
  - ALLOCATE only; mem_write_o never asserts.
- Assert rst_i = 0 during ALLOCATE wait:
  - mem_enable_o drops immediately; stall drops with state IDLE;
  - a reload of the previously resident address misses.
- Force hit_cnt_o to 0xFFFFFFFF via repeated hits or preload:
  - next hit yields 0x00000000.
